// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and message-block helper for the SHA-256
// nonce feeder and its neighbouring hash blocks.
package sha256_pkg;

  localparam logic [31:0] PAD_WORD        = 32'h80000000;
  localparam logic [31:0] LEN_640         = 32'h00000280;
  localparam int          PPL_LATENCY_DEF = 66;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } feeder_state_e;

  // Second header block: tail words 16..18, nonce, padding, length of 640 bits.
  function automatic logic [511:0] build_chunk(input logic [95:0] tail,
                                               input logic [31:0] nonce);
    build_chunk = {tail, nonce, PAD_WORD, 320'd0, LEN_640};
  endfunction

endpackage

// File: rtl/sha256_nonce_feeder.sv
// Walks an inclusive nonce range for one block header and feeds the hash
// pipeline one message per cycle, then waits for the pipeline to drain.
module sha256_nonce_feeder
  import sha256_pkg::*;
#(
  parameter int PPL_LATENCY = PPL_LATENCY_DEF
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         job_valid_i,
  output logic         job_ready_o,
  input  logic [255:0] midstate_i,
  input  logic [95:0]  tail_i,
  input  logic [31:0]  nonce_start_i,
  input  logic [31:0]  nonce_end_i,
  input  logic         stall_i,
  input  logic         abort_i,
  output logic [255:0] init_o,
  output logic [511:0] chunk_o,
  output logic         sha_valid_o,
  output logic [31:0]  nonce_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int DRAIN_W = (PPL_LATENCY > 0) ? $clog2(PPL_LATENCY + 1) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PPL_LATENCY);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_ZERO = {DRAIN_W{1'b0}};

  feeder_state_e      state_q, state_d;
  logic [255:0]       midstate_q, midstate_d;
  logic [95:0]        tail_q, tail_d;
  logic [31:0]        nonce_cur_q, nonce_cur_d;
  logic [31:0]        nonce_end_q, nonce_end_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               sha_valid_s;

  // Next-state logic: job capture, nonce stepping and drain countdown.
  always_comb begin
    state_d     = state_q;
    midstate_d  = midstate_q;
    tail_d      = tail_q;
    nonce_cur_d = nonce_cur_q;
    nonce_end_d = nonce_end_q;
    drain_d     = drain_q;
    sha_valid_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (job_valid_i) begin
          midstate_d  = midstate_i;
          tail_d      = tail_i;
          nonce_cur_d = nonce_start_i;
          nonce_end_d = nonce_end_i;
          state_d     = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sha_valid_s = ~stall_i & ~abort_i;
        if (abort_i) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (sha_valid_s) begin
          // Comparing before incrementing lets start==end+1 cover all 2^32 nonces.
          if (nonce_cur_q == nonce_end_q) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_LOAD;
          end else begin
            nonce_cur_d = nonce_cur_q + 32'd1;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_ZERO) begin
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q - DRAIN_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_comb begin
    done_d  = (state_d == S_DRAIN) && (drain_d == DRAIN_ZERO);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= S_IDLE;
      midstate_q  <= 256'd0;
      tail_q      <= 96'd0;
      nonce_cur_q <= 32'd0;
      nonce_end_q <= 32'd0;
      drain_q     <= DRAIN_ZERO;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      midstate_q  <= midstate_d;
      tail_q      <= tail_d;
      nonce_cur_q <= nonce_cur_d;
      nonce_end_q <= nonce_end_d;
      drain_q     <= drain_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign init_o      = midstate_q;
  assign chunk_o     = build_chunk(tail_q, nonce_cur_q);
  assign nonce_o     = nonce_cur_q;
  assign sha_valid_o = sha_valid_s;
  assign busy_o      = busy_q;
  assign job_ready_o = ready_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_sha256_nonce_feeder.sv
// Directed self-checking bench for sha256_nonce_feeder: single nonce, wrap,
// stall, abort, ignored offers and asynchronous reset mid-run.
module tb_sha256_nonce_feeder;

  logic         clk;
  logic         arst;
  logic         job_valid_i;
  logic         job_ready_o;
  logic [255:0] midstate_i;
  logic [95:0]  tail_i;
  logic [31:0]  nonce_start_i;
  logic [31:0]  nonce_end_i;
  logic         stall_i;
  logic         abort_i;
  logic [255:0] init_o;
  logic [511:0] chunk_o;
  logic         sha_valid_o;
  logic [31:0]  nonce_o;
  logic         busy_o;
  logic         done_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0]  iss_n[$];
  int           iss_c[$];
  logic [511:0] iss_k[$];
  int           done_c[$];

  sha256_nonce_feeder #(.PPL_LATENCY(66)) dut (
    .clk           (clk),
    .arst          (arst),
    .job_valid_i   (job_valid_i),
    .job_ready_o   (job_ready_o),
    .midstate_i    (midstate_i),
    .tail_i        (tail_i),
    .nonce_start_i (nonce_start_i),
    .nonce_end_i   (nonce_end_i),
    .stall_i       (stall_i),
    .abort_i       (abort_i),
    .init_o        (init_o),
    .chunk_o       (chunk_o),
    .sha_valid_o   (sha_valid_o),
    .nonce_o       (nonce_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every issue and every done pulse mid-cycle.
  always @(negedge clk) begin
    if (sha_valid_o) begin
      iss_n.push_back(nonce_o);
      iss_c.push_back(cyc);
      iss_k.push_back(chunk_o);
    end
    if (done_o) done_c.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] exp_chunk(input logic [95:0] tail, input logic [31:0] nonce);
    logic [31:0] w [16];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) w[i] = 32'd0;
    w[0]  = tail[95:64];
    w[1]  = tail[63:32];
    w[2]  = tail[31:0];
    w[3]  = nonce;
    w[4]  = 32'h80000000;
    w[15] = 32'h00000280;
    r = 512'd0;
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [511:0] c, input int idx);
    return c[511-32*idx -: 32];
  endfunction

  task automatic clear_log();
    iss_n.delete();
    iss_c.delete();
    iss_k.delete();
    done_c.delete();
  endtask

  // Offer a job in the current cycle; returns one cycle after acceptance.
  task automatic offer(input logic [255:0] ms, input logic [95:0] tl,
                       input logic [31:0] s, input logic [31:0] e);
    midstate_i    = ms;
    tail_i        = tl;
    nonce_start_i = s;
    nonce_end_i   = e;
    job_valid_i   = 1'b1;
    #1;
    chk("ready_before_accept", 512'(job_ready_o), 512'(1'b1));
    @(posedge clk);
    #1;
    job_valid_i = 1'b0;
  endtask

  // Bounded wait for a done pulse; returns #1 after the following edge.
  task automatic wait_done();
    int n;
    n = 0;
    while (done_c.size() == 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_seen", 512'(done_c.size()), 512'(1));
  endtask

  localparam logic [255:0] MS_A = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] MS_B = 256'h01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  localparam logic [95:0]  TL_A = 96'h4a5e1e4b_495fab29_1d00ffff;
  localparam logic [95:0]  TL_B = 96'hdeadbeef_cafef00d_17034219;

  initial begin
    int abort_cyc;
    logic [31:0] wrap_exp [4];
    arst = 1'b1; job_valid_i = 1'b0; stall_i = 1'b0; abort_i = 1'b0;
    midstate_i = 256'd0; tail_i = 96'd0; nonce_start_i = 32'd0; nonce_end_i = 32'd0;

    // Reset state
    #12;
    chk("rst_sha_valid", 512'(sha_valid_o), 512'(1'b0));
    chk("rst_done", 512'(done_o), 512'(1'b0));
    chk("rst_busy", 512'(busy_o), 512'(1'b0));
    chk("rst_nonce", 512'(nonce_o), 512'(32'd0));
    chk("rst_init", 512'(init_o), 512'(256'd0));
    chk("rst_chunk", chunk_o, exp_chunk(96'd0, 32'd0));
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 512'(job_ready_o), 512'(1'b1));

    // Single nonce
    clear_log();
    offer(MS_A, TL_A, 32'h12345678, 32'h12345678);
    chk("single_busy", 512'(busy_o), 512'(1'b1));
    wait_done();
    chk("single_count", 512'(iss_n.size()), 512'(1));
    if (iss_n.size() > 0) begin
      chk("single_nonce", 512'(iss_n[0]), 512'(32'h12345678));
      chk("single_chunk", iss_k[0], exp_chunk(TL_A, 32'h12345678));
      chk("single_w4", 512'(word_of(iss_k[0], 4)), 512'(32'h80000000));
      chk("single_w15", 512'(word_of(iss_k[0], 15)), 512'(32'h00000280));
      if (done_c.size() > 0) chk("single_done_lat", 512'(done_c[0] - iss_c[0]), 512'(67));
    end
    chk("single_ready_after", 512'(job_ready_o), 512'(1'b1));
    chk("single_busy_after", 512'(busy_o), 512'(1'b0));
    chk("single_init_held", 512'(init_o), 512'(MS_A));

    // Wrap through 0xFFFFFFFF
    clear_log();
    wrap_exp[0] = 32'hFFFFFFFE; wrap_exp[1] = 32'hFFFFFFFF;
    wrap_exp[2] = 32'h00000000; wrap_exp[3] = 32'h00000001;
    offer(MS_B, TL_B, 32'hFFFFFFFE, 32'h00000001);
    wait_done();
    chk("wrap_count", 512'(iss_n.size()), 512'(4));
    for (int i = 0; i < iss_n.size() && i < 4; i++) begin
      chk("wrap_nonce", 512'(iss_n[i]), 512'(wrap_exp[i]));
      chk("wrap_consecutive", 512'(iss_c[i] - iss_c[0]), 512'(i));
    end
    if (iss_c.size() > 0 && done_c.size() > 0)
      chk("wrap_done_lat", 512'(done_c[0] - iss_c[iss_c.size()-1]), 512'(67));

    // Stall for 3 cycles mid-run
    clear_log();
    offer(MS_A, TL_A, 32'd0, 32'd9);
    for (int k = 0; k < 16; k++) begin
      stall_i = (k >= 4 && k < 7);
      @(posedge clk); #1;
    end
    stall_i = 1'b0;
    wait_done();
    chk("stall_count", 512'(iss_n.size()), 512'(10));
    for (int i = 0; i < iss_n.size() && i < 10; i++)
      chk("stall_nonce", 512'(iss_n[i]), 512'(i));
    if (iss_c.size() == 10) chk("stall_span", 512'(iss_c[9] - iss_c[0]), 512'(12));

    // Abort after 5 issues
    clear_log();
    abort_cyc = 0;
    offer(MS_B, TL_B, 32'd100, 32'd200);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
    end
    abort_i = 1'b1;
    #1;
    chk("abort_no_issue", 512'(sha_valid_o), 512'(1'b0));
    abort_cyc = cyc;
    @(posedge clk); #1;
    abort_i = 1'b0;
    stall_i = 1'b1;
    @(posedge clk); #1;
    stall_i = 1'b0;
    wait_done();
    chk("abort_count", 512'(iss_n.size()), 512'(5));
    if (done_c.size() > 0) chk("abort_done_lat", 512'(done_c[0] - abort_cyc), 512'(67));
    chk("abort_ready_after", 512'(job_ready_o), 512'(1'b1));

    // Offers during RUN and DRAIN are ignored, accepted once idle
    clear_log();
    offer(MS_A, TL_A, 32'd0, 32'd2);
    midstate_i = MS_B; tail_i = TL_B;
    nonce_start_i = 32'hABCD0000; nonce_end_i = 32'hABCD0003;
    job_valid_i = 1'b1;
    @(posedge clk); #1;
    chk("ign_run_init", 512'(init_o), 512'(MS_A));
    chk("ign_run_nonce", 512'(nonce_o), 512'(32'd1));
    repeat (10) @(posedge clk);
    #1;
    chk("ign_drain_init", 512'(init_o), 512'(MS_A));
    chk("ign_drain_ready", 512'(job_ready_o), 512'(1'b0));
    chk("ign_drain_tail", 512'(word_of(chunk_o, 0)), 512'(TL_A[95:64]));
    wait_done();
    chk("ign_count", 512'(iss_n.size()), 512'(3));
    if (iss_c.size() == 3 && done_c.size() > 0)
      chk("ign_done_lat", 512'(done_c[0] - iss_c[2]), 512'(67));
    chk("ign_idle_init", 512'(init_o), 512'(MS_A));
    chk("ign_idle_ready", 512'(job_ready_o), 512'(1'b1));
    @(posedge clk); #1;
    job_valid_i = 1'b0;
    chk("accept_init", 512'(init_o), 512'(MS_B));
    chk("accept_nonce", 512'(nonce_o), 512'(32'hABCD0000));
    chk("accept_busy", 512'(busy_o), 512'(1'b1));
    chk("accept_valid", 512'(sha_valid_o), 512'(1'b1));

    // Asynchronous reset mid-run
    clear_log();
    #2;
    arst = 1'b1;
    #1;
    chk("arst_sha_valid", 512'(sha_valid_o), 512'(1'b0));
    chk("arst_busy", 512'(busy_o), 512'(1'b0));
    chk("arst_init", 512'(init_o), 512'(256'd0));
    chk("arst_nonce", 512'(nonce_o), 512'(32'd0));
    @(posedge clk); #1;
    arst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("arst_no_done", 512'(done_c.size()), 512'(0));
    chk("arst_ready", 512'(job_ready_o), 512'(1'b1));
    chk("arst_idle_busy", 512'(busy_o), 512'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_nonce_feeder.md
SHA256_NONCE_FEEDER -- requirements
Module: sha256_nonce_feeder

Interface
REQ-001 Parameter PPL_LATENCY, default 66: cycles from sha_valid_o to the hash pipeline's output valid.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 arst  in  1  reset, asynchronous, active-high.
REQ-004 job_valid_i  in  1  job offered.
REQ-005 job_ready_o  out  1  job accepted this cycle when job_valid_i=1.
REQ-006 midstate_i  in  256  SHA-256 state after the first header block; word 0 in [255:224].
REQ-007 tail_i  in  96  header words 16..18 (merkle tail, time, bits); word 16 in [95:64].
REQ-008 nonce_start_i, nonce_end_i  in  32 each  inclusive nonce range.
REQ-009 stall_i  in  1  suppresses issue this cycle.
REQ-010 abort_i  in  1  terminates the current job.
REQ-011 init_o  out  256  held midstate, drives the pipeline init words; word 0 in [255:224].
REQ-012 chunk_o  out  512  second-block message; chunk word 0 in [511:480].
REQ-013 sha_valid_o  out  1  drives the pipeline valid input.
REQ-014 nonce_o  out  32  nonce carried in chunk word 3.
REQ-015 busy_o  out  1  state is not IDLE.
REQ-016 done_o  out  1  one-cycle pulse when the job ends and its last hash has left the pipeline.

Function
REQ-017 States: IDLE, RUN, DRAIN; job_ready_o=1 only in IDLE.
REQ-018 On job_valid_i & job_ready_o: latch midstate, tail, nonce_cur=nonce_start_i, nonce_end=nonce_end_i; next state RUN.
REQ-019 chunk_o words: 0..2 = latched tail; 3 = nonce_cur; 4 = 32'h80000000; 5..14 = 0; 15 = 32'h00000280.
REQ-020 nonce_o = nonce_cur.
REQ-021 In RUN: sha_valid_o = ~stall_i & ~abort_i (combinational); all other outputs come from registers.
REQ-022 Issue cycle (RUN, sha_valid_o=1): if nonce_cur == nonce_end, go to DRAIN; else nonce_cur increments modulo 2^32.
REQ-023 Range semantics: start==end issues one nonce; start>end wraps through 0xFFFFFFFF to 0; start==end+1 issues all 2^32 nonces.
REQ-024 Stall in RUN: no issue, nonce_cur held, no skip and no repeat.
REQ-025 abort_i in RUN: no issue that cycle; go to DRAIN; abort_i and stall_i ignored in IDLE and DRAIN.
REQ-026 DRAIN: drain counter loaded with PPL_LATENCY on entry, decrements each cycle; at 0, done_o=1 and next state IDLE.
REQ-027 With T = last issue cycle (or abort cycle): done_o pulses in cycle T+PPL_LATENCY+1; job_ready_o rises in T+PPL_LATENCY+2.
REQ-028 init_o and chunk_o tail words stay stable from acceptance until done_o, because the pipeline adds init at its output stage.
REQ-029 job_valid_i outside IDLE has no effect on any state.

Reset
REQ-030 arst asserted: state IDLE immediately; all outputs return to reset values.
REQ-031 Reset values: sha_valid_o=0, done_o=0, busy_o=0, job_ready_o=1 after release, nonce_o=0, init_o=0, chunk_o tail and nonce words=0.
REQ-032 arst during RUN or DRAIN abandons the job with no done_o; pipeline valids are cleared by the same arst.

Structure
REQ-033 Shared sha256_pkg holds: PAD_WORD=32'h80000000, LEN_640=32'h00000280, default PPL_LATENCY=66, state encoding.
REQ-034 Single module, no sub-module; drain counter width = $clog2(PPL_LATENCY+1).

Verification
REQ-035 Single nonce: start=end=0x12345678 -> exactly 1 sha_valid_o cycle, chunk words 3/4/15 = 12345678/80000000/00000280, done_o 67 cycles after that issue.
REQ-036 Wrap: start=0xFFFFFFFE, end=0x00000001 -> nonces FFFFFFFE, FFFFFFFF, 00000000, 00000001 in consecutive cycles, then DRAIN.
REQ-037 Stall: range 0..9 with stall_i high 3 cycles mid-run -> 10 issues over 13 cycles, nonces strictly increasing by 1.
REQ-038 Abort after 5 issues -> no further sha_valid_o; done_o 67 cycles after the abort cycle; job_ready_o the cycle after.
REQ-039 Job offered during RUN and DRAIN -> ignored; init_o unchanged until done_o; accepted once back in IDLE.
REQ-040 Reset and integration:
- arst mid-RUN -> sha_valid_o=0 immediately, IDLE, no done_o.
- With the hash pipeline attached, a known header midstate/tail/nonce -> reference SHA-256 result.
